d_mdu_stall_ctrl: RTL and testbench
===================================

// Module: d_mdu_stall_ctrl
// PURPOSE
//   Issue-side controller for the E-stage multiply/divide unit (E_MDU). Runs a shadow
//   occupancy counter that matches the MDU's start/busy timing exactly.
//   Raises stall_mdu to hold a D-stage MDU instruction while the MDU is starting or busy.
//   Freezes whenever the MDU freezes (req high), so stall timing stays cycle-exact.
//   Sits in the hazard unit; stall_mdu is ORed into the global D/F stall and E bubble.
// PARAMETERS
//   MULT_LAT  4  busy cycles after a mult/multu start cycle
//   DIV_LAT   9  busy cycles after a div/divu start cycle
//   CNT_W     4  counter width; must hold max(MULT_LAT, DIV_LAT)
// PORTS
//   clk        in   1      pipeline clock
//   reset      in   1      asynchronous, active-high reset
//   req        in   1      interrupt/exception request; MDU frozen while high
//   D_sel_MDU  in   4      D-stage MDU op code (0 none, 1 mult..4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo)
//   E_sel_MDU  in   4      E-stage MDU op code (same encoding)
//   mdu_busy   in   1      busy output of E_MDU (used only with MDU_CHECK_EN)
//   stall_mdu  out  1      stall D/F, insert bubble into E
//   busy_sh    out  1      shadow of the MDU busy flag (registered)
//   remain     out  CNT_W  busy cycles left (0 when idle)
//   op_kind    out  2      0 IDLE, 1 MULT, 2 DIV (current state)
//   chk_err    out  1      sticky busy mismatch flag (0 when the feature is off)
// BEHAVIOUR
//   Reset (async, immediate): state IDLE, remain 0, busy_sh 0, chk_err 0. stall_mdu is then 0.
//   e_start = !req && state==IDLE && E_sel_MDU in {1,2,3,4}  (combinational)
//   d_mdu   = D_sel_MDU in {1..8}  (mthi/mtlo/mfhi/mflo also stall)
//   stall_mdu = d_mdu && (e_start || busy_sh)   (combinational, same cycle)
//   FSM (all transitions on posedge clk; no transition while req=1):
//     IDLE: on e_start with op 1/2 -> MULT, remain<=MULT_LAT; with op 3/4 -> DIV, remain<=DIV_LAT.
//           busy_sh<=1 on either. Other E ops (5..8) leave state IDLE.
//     MULT/DIV: remain<=remain-1 each cycle. When remain==1 -> IDLE, remain<=0, busy_sh<=0.
//   Latency: start in cycle N; busy_sh high in cycles N+1..N+LAT; idle again at N+LAT+1.
//   req high: counter, state and busy_sh hold their values. An E op presented while req
//     is high is not started (e_start=0). stall_mdu keeps tracking busy_sh.
//   A new E start while not IDLE is ignored; the MDU also ignores it. No queuing.
//   D and E ops in the same cycle: stall is decided from the current E op (e_start).
//     The E start is registered regardless of the D stall.
//   Reset mid-operation: all state is cleared at once; no residual stall.
//   remain never wraps: decrement happens only in MULT/DIV with remain>=1.
// CONFIGURATION
//   MDU_CHECK_EN defined: at each posedge with !req and !reset, if mdu_busy != busy_sh,
//     then chk_err<=1. chk_err is sticky until reset. Intended for simulation and FPGA debug.
//   MDU_CHECK_EN undefined: chk_err tied to 0; mdu_busy unused; no extra flops.
// TESTING
//   Reset mid-DIV (remain 5) -> outputs clear at once; state 0, stall_mdu 0 before next edge.
//   E=mult, D=mfhi at cycle 0 -> stall_mdu=1 cycles 0..4; busy_sh 1..4; stall_mdu=0 cycle 5.
//   E=divu, D=mtlo at cycle 0 -> stall_mdu=1 cycles 0..9; remain 9,8..1; op_kind=2.
//   E=mult at cycle 0, req=1 cycles 2..4 -> remain held at 3; busy_sh falls at cycle 8.
//   E=div while MULT remain=2 -> ignored; IDLE after 2 cycles; D=0 -> stall_mdu stays 0.
//   MDU_CHECK_EN: force mdu_busy=0 during a MULT -> chk_err=1 next edge, held until reset.

Source files
------------

// File: rtl/d_mdu_stall_ctrl.sv
// Issue-side MDU stall controller with a shadow busy/occupancy counter.
// Optional busy cross-check against E_MDU enabled by MDU_CHECK_EN.
module d_mdu_stall_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 9,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [3:0]       D_sel_MDU,
    input  logic [3:0]       E_sel_MDU,
    input  logic             mdu_busy,
    output logic             stall_mdu,
    output logic             busy_sh,
    output logic [CNT_W-1:0] remain,
    output logic [1:0]       op_kind,
    output logic             chk_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] remain_nx;
    logic             busy_q;
    logic             busy_nx;
    logic             e_mult;
    logic             e_div;
    logic             e_start;
    logic             d_mdu;

    always_comb begin
        e_mult  = (E_sel_MDU == 4'd1) || (E_sel_MDU == 4'd2);
        e_div   = (E_sel_MDU == 4'd3) || (E_sel_MDU == 4'd4);
        e_start = !req && (state == IDLE) && (e_mult || e_div);
        d_mdu   = (D_sel_MDU != 4'd0) && (D_sel_MDU <= 4'd8);
    end

    assign stall_mdu = d_mdu && (e_start || busy_q);
    assign busy_sh   = busy_q;
    assign remain    = remain_q;
    assign op_kind   = state;

    // Everything holds while req is high, mirroring the frozen MDU.
    always_comb begin
        state_nx  = state;
        remain_nx = remain_q;
        busy_nx   = busy_q;
        if (!req) begin
            unique case (state)
                IDLE: begin
                    if (e_start) begin
                        busy_nx = 1'b1;
                        if (e_mult) begin
                            state_nx  = MULT;
                            remain_nx = CNT_W'(MULT_LAT);
                        end else begin
                            state_nx  = DIV;
                            remain_nx = CNT_W'(DIV_LAT);
                        end
                    end
                end
                MULT, DIV: begin
                    if (remain_q <= CNT_W'(1)) begin
                        state_nx  = IDLE;
                        remain_nx = '0;
                        busy_nx   = 1'b0;
                    end else begin
                        remain_nx = remain_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_nx  = IDLE;
                    remain_nx = '0;
                    busy_nx   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            remain_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            remain_q <= remain_nx;
            busy_q   <= busy_nx;
        end
    end

`ifdef MDU_CHECK_EN
    logic chk_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= 1'b0;
        end else if (!req && (mdu_busy != busy_q)) begin
            chk_q <= 1'b1;
        end
    end

    assign chk_err = chk_q;
`else
    logic unused_mdu_busy;

    assign unused_mdu_busy = mdu_busy;
    assign chk_err         = 1'b0;
`endif

endmodule

// File: tb/tb_d_mdu_stall_ctrl.sv
// Bench for d_mdu_stall_ctrl: directed scenarios plus random traffic
// against an occupancy model; chk_err scenario only with MDU_CHECK_EN.
module tb_d_mdu_stall_ctrl;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 9;

    logic       clk;
    logic       reset;
    logic       req;
    logic [3:0] D_sel_MDU;
    logic [3:0] E_sel_MDU;
    logic       mdu_busy;
    logic       stall_mdu;
    logic       busy_sh;
    logic [3:0] remain;
    logic [1:0] op_kind;
    logic       chk_err;

    int n_cmp;
    int n_bad;

    // Model: cycles of occupancy left and the kind of op occupying the MDU
    int m_left;
    int m_kind;

    d_mdu_stall_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .D_sel_MDU (D_sel_MDU),
        .E_sel_MDU (E_sel_MDU),
        .mdu_busy  (mdu_busy),
        .stall_mdu (stall_mdu),
        .busy_sh   (busy_sh),
        .remain    (remain),
        .op_kind   (op_kind),
        .chk_err   (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_kind = 0;
        end else if (!req) begin
            if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (E_sel_MDU >= 1 && E_sel_MDU <= 4) begin
                m_kind = (E_sel_MDU <= 2) ? 1 : 2;
                m_left = (E_sel_MDU <= 2) ? MULT_LAT : DIV_LAT;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        mdu_busy = (m_left > 0);
    endtask

    task automatic drive(input bit r, input int e, input int d);
        req       = r;
        E_sel_MDU = 4'(e);
        D_sel_MDU = 4'(d);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0);
        mdu_busy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({stall_mdu, busy_sh, remain, op_kind, chk_err} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset: got %b want 000000000",
                     {stall_mdu, busy_sh, remain, op_kind, chk_err});
        end
        #2 reset = 1'b0;
        step();
    endtask

    task automatic test_mult_mfhi();
        logic [7:0] exp;
        for (int i = 0; i <= 6; i++) begin
            drive(0, (i == 0) ? 1 : 0, 5);
            exp = {(i <= 4) ? 1'b1 : 1'b0,
                   (i >= 1 && i <= 4) ? 1'b1 : 1'b0,
                   (i >= 1 && i <= 4) ? 4'(5 - i) : 4'd0,
                   (i >= 1 && i <= 4) ? 2'd1 : 2'd0};
            @(negedge clk);
            n_cmp++;
            if ({stall_mdu, busy_sh, remain, op_kind} !== exp) begin
                n_bad++;
                $display("FAIL mult_mfhi c%0d: got %b want %b", i,
                         {stall_mdu, busy_sh, remain, op_kind}, exp);
            end
            step();
        end
    endtask

    task automatic test_divu_mtlo();
        logic [7:0] exp;
        for (int i = 0; i <= 11; i++) begin
            drive(0, (i == 0) ? 4 : 0, 8);
            exp = {(i <= 9) ? 1'b1 : 1'b0,
                   (i >= 1 && i <= 9) ? 1'b1 : 1'b0,
                   (i >= 1 && i <= 9) ? 4'(10 - i) : 4'd0,
                   (i >= 1 && i <= 9) ? 2'd2 : 2'd0};
            @(negedge clk);
            n_cmp++;
            if ({stall_mdu, busy_sh, remain, op_kind} !== exp) begin
                n_bad++;
                $display("FAIL divu_mtlo c%0d: got %b want %b", i,
                         {stall_mdu, busy_sh, remain, op_kind}, exp);
            end
            step();
        end
    endtask

    task automatic test_req_freeze();
        bit   t_req [11] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0};
        int   t_e   [11] = '{1, 0, 0, 3, 0, 0, 0, 0, 0, 3, 0};
        int   t_d   [11] = '{0, 5, 5, 5, 5, 0, 0, 0, 0, 1, 0};
        bit   t_st  [11] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        bit   t_bz  [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        int   t_rm  [11] = '{0, 4, 3, 3, 3, 3, 2, 1, 0, 0, 0};
        logic [5:0] exp;
        for (int i = 0; i < 11; i++) begin
            drive(t_req[i], t_e[i], t_d[i]);
            exp = {t_st[i], t_bz[i], 4'(t_rm[i])};
            @(negedge clk);
            n_cmp++;
            if ({stall_mdu, busy_sh, remain} !== exp) begin
                n_bad++;
                $display("FAIL req_freeze c%0d: got %b want %b", i,
                         {stall_mdu, busy_sh, remain}, exp);
            end
            step();
        end
    endtask

    task automatic test_ignore_start();
        int t_e  [6] = '{1, 0, 0, 3, 0, 0};
        int t_rm [6] = '{0, 4, 3, 2, 1, 0};
        int t_k  [6] = '{0, 1, 1, 1, 1, 0};
        logic [6:0] exp;
        for (int i = 0; i < 6; i++) begin
            drive(0, t_e[i], 0);
            exp = {1'b0, 4'(t_rm[i]), 2'(t_k[i])};
            @(negedge clk);
            n_cmp++;
            if ({stall_mdu, remain, op_kind} !== exp) begin
                n_bad++;
                $display("FAIL ignore_start c%0d: got %b want %b", i,
                         {stall_mdu, remain, op_kind}, exp);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_div();
        for (int i = 0; i <= 5; i++) begin
            drive(0, (i == 0) ? 3 : 0, 5);
            if (i < 5) step();
        end
        @(negedge clk);
        n_cmp++;
        if (remain !== 4'd5) begin
            n_bad++;
            $display("FAIL rst_mid_div pre: remain %0d want 5", remain);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({stall_mdu, busy_sh, remain, op_kind} !== 8'b0) begin
            n_bad++;
            $display("FAIL rst_mid_div async: got %b want 00000000",
                     {stall_mdu, busy_sh, remain, op_kind});
        end
        mdu_busy = 1'b0;
        #1 reset = 1'b0;
        step();
        @(negedge clk);
        n_cmp++;
        if ({stall_mdu, busy_sh, remain, op_kind} !== 8'b0) begin
            n_bad++;
            $display("FAIL rst_mid_div after: got %b want 00000000",
                     {stall_mdu, busy_sh, remain, op_kind});
        end
        step();
    endtask

    task automatic test_random();
        logic [8:0] exp;
        bit         e_st;
        bit         d_op;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 4) == 0), $urandom_range(0, 15),
                  $urandom_range(0, 12));
            e_st = !req && (m_left == 0) && E_sel_MDU >= 1 && E_sel_MDU <= 4;
            d_op = D_sel_MDU >= 1 && D_sel_MDU <= 8;
            exp  = {d_op && (e_st || m_left > 0), m_left > 0, 4'(m_left),
                    (m_left > 0) ? 2'(m_kind) : 2'd0, 1'b0};
            @(negedge clk);
            n_cmp++;
            if ({stall_mdu, busy_sh, remain, op_kind, chk_err} !== exp) begin
                n_bad++;
                $display("FAIL random c%0d: got %b want %b", i,
                         {stall_mdu, busy_sh, remain, op_kind, chk_err}, exp);
            end
            step();
        end
        drive(0, 0, 0);
        for (int i = 0; i < 12; i++) step();
    endtask

`ifdef MDU_CHECK_EN
    task automatic test_chk();
        drive(0, 1, 0);
        step();
        drive(0, 0, 0);
        mdu_busy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_bad++;
            $display("FAIL chk pre: got %b want 0", chk_err);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (chk_err !== 1'b1) begin
                n_bad++;
                $display("FAIL chk sticky c%0d: got %b want 1", i, chk_err);
            end
            step();
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_bad++;
            $display("FAIL chk reset: got %b want 0", chk_err);
        end
        mdu_busy = 1'b0;
        #1 reset = 1'b0;
        step();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mult_mfhi();
        test_divu_mtlo();
        test_req_freeze();
        test_ignore_start();
        test_reset_mid_div();
        test_random();
`ifdef MDU_CHECK_EN
        test_chk();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
